inst_sequencer: RTL and testbench



---
 rtl/inst_sequencer.sv | 116 +++++++++++
 tb/tb_inst_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches from program memory into IR, strobes
// the datapath once per instruction and resolves jumps and halt/resume.
module inst_sequencer #(
    parameter int PC_W  = 16,
    parameter int DELAY = 4
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic            resume,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            zero_flag,
    input  logic            carry_flag,
    input  logic            sign_flag,
    input  logic            overflow_flag,
    output logic [31:0]     IR,
    output logic            exec_en,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            busy
);

    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_DELAY,
        S_NEXT,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            taken;
    logic [31:0]     ir;
    logic [4:0]      oper;
    logic            is_jump;
    logic            is_halt;
    logic            cond;

    assign oper = ir[31:27];

    always_comb begin
        is_jump = 1'b0;
        is_halt = 1'b0;
        cond    = 1'b0;
        case (oper)
            5'd12: begin is_jump = 1'b1; cond = 1'b1;           end
            5'd13: begin is_jump = 1'b1; cond = carry_flag;     end
            5'd14: begin is_jump = 1'b1; cond = !carry_flag;    end
            5'd15: begin is_jump = 1'b1; cond = sign_flag;      end
            5'd16: begin is_jump = 1'b1; cond = !sign_flag;     end
            5'd17: begin is_jump = 1'b1; cond = zero_flag;      end
            5'd18: begin is_jump = 1'b1; cond = !zero_flag;     end
            5'd19: begin is_jump = 1'b1; cond = overflow_flag;  end
            5'd20: begin is_jump = 1'b1; cond = !overflow_flag; end
            5'd27: is_halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = S_EXEC;
            S_EXEC:  state_nx = is_halt ? S_HALT : S_DELAY;
            S_DELAY: if (cnt == CW'(DELAY - 1)) state_nx = S_NEXT;
            S_NEXT:  state_nx = S_FETCH;
            S_HALT:  if (resume) state_nx = S_NEXT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            cnt   <= '0;
            taken <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start) pc <= '0;
                S_LOAD: ir <= imem_rdata;
                S_EXEC: begin
                    taken <= is_jump && cond;
                    cnt   <= '0;
                end
                S_DELAY: cnt <= cnt + CW'(1);
                S_NEXT: begin
                    // plain increment wraps modulo 2^PC_W
                    pc    <= taken ? ir[PC_W-1:0] : pc + PC_W'(1);
                    taken <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign imem_en   = (state == S_FETCH);
    assign imem_addr = pc;
    assign IR        = ir;
    assign exec_en   = (state == S_EXEC) && !is_jump && !is_halt;
    assign halted    = (state == S_HALT);
    assign busy      = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: expected fetch addresses and
// execute strobes are queued by the stimulus and popped by monitors.
module tb_inst_sequencer;

    typedef struct {
        logic [31:0] ir;
        int          gap;
    } ex_t;

    localparam logic [31:0] W_MUL  = 32'h2080_0800;
    localparam logic [31:0] W_OP0  = 32'h00C0_0000;
    localparam logic [31:0] W_HALT = 32'hD800_0000;
    localparam logic [31:0] W_JMP  = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic        resume = 1'b0;
    logic        zf = 1'b0, cf = 1'b0, sf = 1'b0, vf = 1'b0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] rdata = '0;
    logic [31:0] ir;
    logic        exec_en, halted, busy;
    logic [15:0] pc;

    logic        rst_b = 1'b1;
    logic        start_b = 1'b0;
    logic        imem_en_b;
    logic [15:0] imem_addr_b;
    logic [31:0] rdata_b = '0;
    logic [31:0] ir_b;
    logic        exec_en_b, halted_b, busy_b;
    logic [15:0] pc_b;

    bit [31:0]   mem [0:65535];
    logic [15:0] fq[$];
    ex_t         eq[$];
    int          gq_b[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_a = 0;
    int          last_b = 0;

    inst_sequencer #(.PC_W(16), .DELAY(4)) dut_a (
        .clk(clk), .sys_rst(sys_rst), .start(start), .resume(resume),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(rdata),
        .zero_flag(zf), .carry_flag(cf), .sign_flag(sf),
        .overflow_flag(vf), .IR(ir), .exec_en(exec_en), .pc(pc),
        .halted(halted), .busy(busy)
    );

    inst_sequencer #(.PC_W(16), .DELAY(1)) dut_b (
        .clk(clk), .sys_rst(rst_b), .start(start_b), .resume(1'b0),
        .imem_en(imem_en_b), .imem_addr(imem_addr_b),
        .imem_rdata(rdata_b), .zero_flag(1'b0), .carry_flag(1'b0),
        .sign_flag(1'b0), .overflow_flag(1'b0), .IR(ir_b),
        .exec_en(exec_en_b), .pc(pc_b), .halted(halted_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_en) rdata <= mem[imem_addr];
        if (imem_en_b) rdata_b <= mem[imem_addr_b];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!sys_rst && imem_en) begin
            if (fq.size() == 0) chk("fetch_unexpected", {16'h0, imem_addr}, 32'hFFFF_FFFF);
            else chk("fetch_addr", {16'h0, imem_addr}, {16'h0, fq.pop_front()});
        end
        if (!sys_rst && exec_en) begin
            if (eq.size() == 0) chk("exec_unexpected", ir, 32'hFFFF_FFFF);
            else begin
                ex_t e;
                e = eq.pop_front();
                chk("exec_ir", ir, e.ir);
                if (e.gap != 0) chk("exec_gap", cyc - last_a, e.gap);
            end
            last_a = cyc;
        end
        if (!rst_b && exec_en_b) begin
            if (gq_b.size() == 0) chk("b_exec_unexpected", ir_b, 32'hFFFF_FFFF);
            else begin
                int g;
                g = gq_b.pop_front();
                if (g != 0) chk("b_exec_gap", cyc - last_b, g);
            end
            last_b = cyc;
        end
    end

    task automatic reset_a();
        @(negedge clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string nm);
        int n;
        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!halted) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_empty(input string nm);
        chk({nm, "_fq_left"}, fq.size(), 0);
        chk({nm, "_eq_left"}, eq.size(), 0);
        fq.delete();
        eq.delete();
    endtask

    initial begin
        int idx, sel, n;
        logic tk;

        repeat (2) @(negedge clk);
        chk("rst_pc", {16'h0, pc}, 0);
        chk("rst_ir", ir, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("idle_imem_en", {31'h0, imem_en}, 0);
        chk("idle_halted", {31'h0, halted}, 0);

        // straight-line program ending in HALT
        mem[0] = W_MUL;
        mem[1] = W_OP0;
        mem[2] = W_HALT;
        fq.push_back(16'd0);
        fq.push_back(16'd1);
        fq.push_back(16'd2);
        eq.push_back('{W_MUL, 0});
        eq.push_back('{W_OP0, 8});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_imem_en", {31'h0, imem_en}, 1);
        chk("start_addr", {16'h0, imem_addr}, 0);
        wait_halt("line");
        chk("line_pc", {16'h0, pc}, 2);
        chk("line_busy", {31'h0, busy}, 0);
        chk("line_ir", ir, W_HALT);
        chk_empty("line");

        // reset while counting out the delay
        reset_a();
        fq.push_back(16'd0);
        eq.push_back('{W_MUL, 0});
        pulse_start();
        n = 0;
        while (eq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("mid_busy", {31'h0, busy}, 1);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_pc", {16'h0, pc}, 0);
        chk("mid_rst_ir", ir, 0);
        chk("mid_rst_exec", {31'h0, exec_en}, 0);
        chk("mid_rst_busy", {31'h0, busy}, 0);
        chk_empty("mid");
        @(negedge clk);
        sys_rst = 1'b0;

        // every conditional jump with its flag at both values
        for (int op = 13; op <= 20; op++) begin
            for (int f = 0; f < 2; f++) begin
                idx = op - 13;
                sel = idx / 2;
                tk = (idx % 2 == 0) ? f[0] : !f[0];
                reset_a();
                cf = !f[0]; sf = !f[0]; zf = !f[0]; vf = !f[0];
                case (sel)
                    0: cf = f[0];
                    1: sf = f[0];
                    2: zf = f[0];
                    default: vf = f[0];
                endcase
                mem[0] = (32'(op) << 27) | 32'h10;
                mem[1] = W_HALT;
                mem[16] = W_HALT;
                fq.push_back(16'd0);
                fq.push_back(tk ? 16'h10 : 16'h1);
                pulse_start();
                wait_halt("cj");
                chk($sformatf("cj_pc_op%0d_f%0d", op, f),
                    {16'h0, pc}, tk ? 32'h10 : 32'h1);
                chk_empty("cj");
            end
        end

        // unconditional jumps and pc wrap
        reset_a();
        mem[0] = W_JMP | 32'h5;
        mem[5] = W_JMP | 32'hFFFF;
        mem[16'hFFFF] = 32'h0;
        fq.push_back(16'h0);
        fq.push_back(16'h5);
        fq.push_back(16'hFFFF);
        fq.push_back(16'h0);
        eq.push_back('{32'h0, 0});
        pulse_start();
        n = 0;
        while (fq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk_empty("wrap");
        reset_a();

        // halt holds, start is ignored, resume advances the pc
        mem[0] = W_JMP | 32'h7;
        mem[7] = W_HALT;
        mem[8] = W_HALT;
        fq.push_back(16'h0);
        fq.push_back(16'h7);
        pulse_start();
        wait_halt("hr");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = (i == 50);
            if (i % 10 == 9) begin
                chk("hold_halted", {31'h0, halted}, 1);
                chk("hold_busy", {31'h0, busy}, 0);
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold_pc", {16'h0, pc}, 7);
        chk_empty("hold");
        fq.push_back(16'h8);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_halted", {31'h0, halted}, 0);
        wait_halt("resume");
        chk("resume_pc", {16'h0, pc}, 8);
        chk_empty("resume");

        // DELAY=1 instance
        mem[0] = 32'h0;
        mem[1] = W_OP0;
        mem[2] = W_MUL;
        mem[3] = W_HALT;
        gq_b.push_back(0);
        gq_b.push_back(5);
        gq_b.push_back(5);
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!halted_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_halted", {31'h0, halted_b}, 1);
        chk("b_pc", {16'h0, pc_b}, 3);
        chk("b_gq_left", gq_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
